buffer_2: RTL and testbench
===========================

Name: buffer_2

Overview:
- Second-stage output buffer of the edge-detection pipeline.
- Captures nine 8-bit processed (filtered) pixel sums in one `i_save` strobe.
- Presents them one at a time to the downstream memory writer as 32-bit grayscale RGB words.
- Advances to the next entry on each `i_write_complete` handshake and reports full/empty status upstream.

Parameters:
- `PAD_BYTE`, `8'h00`: value placed in `o_buffer2_data[7:0]` (alpha/pad byte).
- `NUM_SUMS`: localparam fixed at 9. Not overridable; it matches the port list.

Ports:
- `clk` input 1: system clock, rising-edge.
- `n_rst` input 1: asynchronous active-low reset.
- `i_processed_sum_1` … `i_processed_sum_9` input 8 each: pixel sums, entry 1 presented first.
- `i_save` input 1: one-cycle strobe that captures all nine sums.
- `i_write_complete` input 1: one-cycle strobe meaning the writer consumed the current word.
- `o_empty` output 1: no unconsumed entries.
- `o_full` output 1: all nine entries held and none consumed yet.
- `o_buffer2_data` output 32: `{cur, cur, cur, PAD_BYTE}`, where `cur` is the current entry (R=G=B).
- `o_start_next_write` output 1: one-cycle pulse telling the writer a new word is valid.

Behaviour:
- **Reset** (async, any time, including mid-drain):
  - Storage cleared to 0, read index = 0, count = 0.
  - `o_empty`=1, `o_full`=0, `o_start_next_write`=0, `o_buffer2_data`={24'h0, PAD_BYTE}.
- **Storage**: 9×8-bit registers. 4-bit read index `rd_idx` (0..8). 4-bit count `cnt` (0..9).
- **Save**:
  - Condition: `i_save`=1 at a rising edge while `o_empty`=1.
  - Sums 1..9 are registered into entries 0..8, `cnt`←9, `rd_idx`←0.
  - The next cycle shows `o_full`=1, `o_empty`=0, data=entry 0.
  - `o_start_next_write` pulses high for exactly one cycle in that same next cycle.
- **`i_save` while not empty**: ignored, contents unchanged.
- **Write-complete**:
  - Condition: `i_write_complete`=1 at an edge while not empty.
  - `cnt` decrements. If `cnt` was >1, `rd_idx` increments.
  - One-cycle latency: the following cycle shows the next entry.
  - When a new entry became current, `o_start_next_write` pulses one cycle.
- **`i_write_complete` while empty**: ignored.
- **Last-entry consume** (`cnt` 1→0):
  - `o_empty`=1, `o_full`=0.
  - `o_buffer2_data` holds the last entry (sum 9). The data register is not cleared.
  - No `o_start_next_write` pulse.
- **Flags**:
  - `o_full` = (`cnt`==9).
  - `o_empty` = (`cnt`==0).
  - Both registered or decoded from registered `cnt`; never both 1.
- **Simultaneous `i_save` and `i_write_complete`**:
  - When empty: save wins.
  - When not empty: write_complete processed, save ignored.
- **Input changes**: changes on `i_processed_sum_*` without `i_save` have no effect on outputs.
- **Strobe width**: multi-cycle strobes are treated as one event per edge.
- All outputs are registered or decoded from registers. No combinational path from inputs to outputs.

Optional Feature:
- Macro: `BUFFER2_INVERT_EN`.
- Defined: each stored byte is inverted (`255 - sum`) at capture; output is `{~s,~s,~s,PAD_BYTE}`.
- Undefined: bytes are stored and output unmodified.
- Flags and handshake timing are identical in both builds.

Decomposition:
- Package `buffer2_pkg`:
  - `PIX_W`=8, `NUM_SUMS`=9.
  - `typedef logic [7:0] pix_t`.
  - `typedef logic [3:0] idx_t`.
- No sub-module needed. Pack logic is a single assign and the control is a counter, not an FSM.

Test Plan:
1. Reset mid-operation (assert `n_rst` low one cycle after a save) → `o_empty`=1, `o_full`=0, data[31:8]=0, `o_start_next_write`=0.
2. Save sums {12,21,252,40,67,255,117,134,239} → after 2 edges: `o_full`=1, `o_empty`=0, data[31:8]=24'h0C0C0C, one `o_start_next_write` pulse; data stable 5 more cycles.
3. Eight `i_write_complete` pulses, spaced 7 cycles apart → data[31:8] steps through 151515, FCFCFC, 282828, 434343, FFFFFF, 757575, 868686, EFEFEF; `o_full`=0, `o_empty`=0; one start pulse per step.
4. Ninth `i_write_complete` → `o_empty`=1, `o_full`=0, data[31:8] stays EFEFEF, no start pulse.
5. Change sums without `i_save`, and pulse `i_save` while non-empty → outputs unchanged. `i_write_complete` while empty → no change.
6. Simultaneous `i_save` and `i_write_complete` while empty → save accepted, `o_full`=1, data = new entry 0.

Source files
------------

// File: rtl/buffer2_pkg.sv
// Shared types and sizes for the second-stage output buffer.
// BUFFER2_INVERT_EN selects inverted-pixel capture.
package buffer2_pkg;

    localparam int unsigned PIX_W    = 8;
    localparam int unsigned NUM_SUMS = 9;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned DATA_W   = 32;

    typedef logic [PIX_W-1:0] pix_t;
    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t CNT_FULL = idx_t'(NUM_SUMS);

    // Value stored for a captured sum; inversion equals 255 - sum for 8-bit data.
    function automatic pix_t capture_xform(input pix_t s);
`ifdef BUFFER2_INVERT_EN
        return ~s;
`else
        return s;
`endif
    endfunction

endpackage

// File: rtl/buffer_2.sv
// Nine-entry pixel buffer draining one grayscale RGB word per writer handshake.
// Build with BUFFER2_INVERT_EN to store inverted pixels.
module buffer_2
    import buffer2_pkg::*;
#(
    parameter logic [PIX_W-1:0] PAD_BYTE = 8'h00
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [PIX_W-1:0]  i_processed_sum_1,
    input  logic [PIX_W-1:0]  i_processed_sum_2,
    input  logic [PIX_W-1:0]  i_processed_sum_3,
    input  logic [PIX_W-1:0]  i_processed_sum_4,
    input  logic [PIX_W-1:0]  i_processed_sum_5,
    input  logic [PIX_W-1:0]  i_processed_sum_6,
    input  logic [PIX_W-1:0]  i_processed_sum_7,
    input  logic [PIX_W-1:0]  i_processed_sum_8,
    input  logic [PIX_W-1:0]  i_processed_sum_9,
    input  logic              i_save,
    input  logic              i_write_complete,
    output logic              o_empty,
    output logic              o_full,
    output logic [DATA_W-1:0] o_buffer2_data,
    output logic              o_start_next_write
);

    pix_t mem_q [NUM_SUMS];
    pix_t mem_d [NUM_SUMS];
    pix_t sums_c [NUM_SUMS];
    idx_t rd_idx_q, rd_idx_d;
    idx_t cnt_q, cnt_d;
    pix_t cur_q, cur_d;
    logic start_q, start_d;
    logic empty_q, empty_d;
    logic full_q, full_d;
    idx_t rd_nxt_c;

    always_comb begin
        sums_c[0] = i_processed_sum_1;
        sums_c[1] = i_processed_sum_2;
        sums_c[2] = i_processed_sum_3;
        sums_c[3] = i_processed_sum_4;
        sums_c[4] = i_processed_sum_5;
        sums_c[5] = i_processed_sum_6;
        sums_c[6] = i_processed_sum_7;
        sums_c[7] = i_processed_sum_8;
        sums_c[8] = i_processed_sum_9;
    end

    assign rd_nxt_c = rd_idx_q + idx_t'(1);

    // Save only when empty; otherwise a write-complete consumes the current entry.
    always_comb begin
        mem_d    = mem_q;
        rd_idx_d = rd_idx_q;
        cnt_d    = cnt_q;
        cur_d    = cur_q;
        start_d  = 1'b0;
        if ((cnt_q == '0) && i_save) begin
            for (int unsigned i = 0; i < NUM_SUMS; i++) begin
                mem_d[i] = capture_xform(sums_c[i]);
            end
            cnt_d    = CNT_FULL;
            rd_idx_d = '0;
            cur_d    = capture_xform(sums_c[0]);
            start_d  = 1'b1;
        end else if ((cnt_q != '0) && i_write_complete) begin
            cnt_d = cnt_q - idx_t'(1);
            // Last entry stays on the bus after it is consumed.
            if (cnt_q > idx_t'(1)) begin
                rd_idx_d = rd_nxt_c;
                cur_d    = mem_q[rd_nxt_c];
                start_d  = 1'b1;
            end
        end
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == CNT_FULL);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int unsigned i = 0; i < NUM_SUMS; i++) begin
                mem_q[i] <= '0;
            end
            rd_idx_q <= '0;
            cnt_q    <= '0;
            cur_q    <= '0;
            start_q  <= 1'b0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rd_idx_q <= rd_idx_d;
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            start_q  <= start_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    assign o_empty            = empty_q;
    assign o_full             = full_q;
    assign o_start_next_write = start_q;
    assign o_buffer2_data     = {cur_q, cur_q, cur_q, PAD_BYTE};

endmodule

// File: tb/tb_buffer_2.sv
// Self-checking bench for buffer_2: queue-based reference model plus directed literal checks.
module tb_buffer_2;

    localparam logic [7:0] PAD = 8'hA5;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [7:0]  s [9];
    logic        i_save = 1'b0;
    logic        i_write_complete = 1'b0;
    logic        o_empty, o_full, o_start_next_write;
    logic [31:0] o_buffer2_data;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    logic        chk_en = 1'b0;

    logic [7:0] m_q [$];
    logic [7:0] m_cur = 8'h00;
    logic       m_pulse = 1'b0;

    buffer_2 #(.PAD_BYTE(PAD)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .i_processed_sum_1  (s[0]),
        .i_processed_sum_2  (s[1]),
        .i_processed_sum_3  (s[2]),
        .i_processed_sum_4  (s[3]),
        .i_processed_sum_5  (s[4]),
        .i_processed_sum_6  (s[5]),
        .i_processed_sum_7  (s[6]),
        .i_processed_sum_8  (s[7]),
        .i_processed_sum_9  (s[8]),
        .i_save             (i_save),
        .i_write_complete   (i_write_complete),
        .o_empty            (o_empty),
        .o_full             (o_full),
        .o_buffer2_data     (o_buffer2_data),
        .o_start_next_write (o_start_next_write)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xf(input logic [7:0] b);
`ifdef BUFFER2_INVERT_EN
        return 8'(8'd255 - b);
`else
        return b;
`endif
    endfunction

    function automatic logic [23:0] lit(input logic [7:0] b);
        logic [7:0] x;
        x = xf(b);
        return {x, x, x};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the buffer is a queue of remaining entries; the bus shows the head.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_q.delete();
            m_cur   = 8'h00;
            m_pulse = 1'b0;
        end else begin
            m_pulse = 1'b0;
            if (m_q.size() == 0) begin
                if (i_save) begin
                    for (int k = 0; k < 9; k++) m_q.push_back(xf(s[k]));
                    m_cur   = m_q[0];
                    m_pulse = 1'b1;
                end
            end else if (i_write_complete) begin
                void'(m_q.pop_front());
                if (m_q.size() > 0) begin
                    m_cur   = m_q[0];
                    m_pulse = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_empty", 32'(o_empty), 32'(m_q.size() == 0));
            chk("model_full",  32'(o_full),  32'(m_q.size() == 9));
            chk("model_data",  o_buffer2_data, {m_cur, m_cur, m_cur, PAD});
            chk("model_start", 32'(o_start_next_write), 32'(m_pulse));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [7:0] v [9]);
        for (int k = 0; k < 9; k++) s[k] = v[k];
    endtask

    logic [7:0] va [9] = '{8'd12, 8'd21, 8'd252, 8'd40, 8'd67, 8'd255, 8'd117, 8'd134, 8'd239};
    logic [7:0] vb [9] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    logic [7:0] vc [9] = '{8'd200, 8'd201, 8'd202, 8'd203, 8'd204, 8'd205, 8'd206, 8'd207, 8'd208};
    logic [7:0] vd [9] = '{8'd99, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

    initial begin
        for (int k = 0; k < 9; k++) s[k] = 8'h00;
        tick();
        chk_en = 1'b1;
        @(negedge clk);
        chk("por_empty", 32'(o_empty), 32'd1);
        chk("por_data", o_buffer2_data, {24'h0, PAD});
        tick();
        n_rst = 1'b1;

        // Reset one cycle after a save
        load(va);
        i_save = 1'b1;
        tick();
        i_save = 1'b0;
        n_rst = 1'b0;
        @(negedge clk);
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_full", 32'(o_full), 32'd0);
        chk("rst_data", o_buffer2_data, {24'h0, PAD});
        chk("rst_start", 32'(o_start_next_write), 32'd0);
        tick();
        n_rst = 1'b1;

        // Save and hold
        i_save = 1'b1;
        tick();
        i_save = 1'b0;
        @(negedge clk);
        chk("save_full", 32'(o_full), 32'd1);
        chk("save_empty", 32'(o_empty), 32'd0);
        chk("save_data", 32'(o_buffer2_data[31:8]), 32'(lit(8'd12)));
        chk("save_start", 32'(o_start_next_write), 32'd1);
        repeat (5) tick();
        chk("hold_data", 32'(o_buffer2_data[31:8]), 32'(lit(8'd12)));
        chk("hold_start", 32'(o_start_next_write), 32'd0);

        // Drain steps 1..8
        for (int k = 1; k < 9; k++) begin
            i_write_complete = 1'b1;
            tick();
            i_write_complete = 1'b0;
            @(negedge clk);
            chk($sformatf("step%0d_data", k), 32'(o_buffer2_data[31:8]), 32'(lit(va[k])));
            chk($sformatf("step%0d_start", k), 32'(o_start_next_write), 32'd1);
            chk($sformatf("step%0d_flags", k), {30'd0, o_full, o_empty}, 32'd0);
            repeat (6) tick();
        end

        // Last consume
        i_write_complete = 1'b1;
        tick();
        i_write_complete = 1'b0;
        @(negedge clk);
        chk("last_empty", 32'(o_empty), 32'd1);
        chk("last_full", 32'(o_full), 32'd0);
        chk("last_data", 32'(o_buffer2_data[31:8]), 32'(lit(8'd239)));
        chk("last_start", 32'(o_start_next_write), 32'd0);

        // Ignored inputs
        load(vc);
        tick();
        i_write_complete = 1'b1;
        tick();
        i_write_complete = 1'b0;
        tick();
        chk("idle_data", 32'(o_buffer2_data[31:8]), 32'(lit(8'd239)));
        load(vb);
        i_save = 1'b1;
        tick();
        load(vc);
        tick();
        i_save = 1'b0;
        tick();
        chk("busy_save_data", 32'(o_buffer2_data[31:8]), 32'(lit(8'd1)));
        chk("busy_save_full", 32'(o_full), 32'd1);
        i_write_complete = 1'b1;
        repeat (9) tick();
        i_write_complete = 1'b0;
        tick();
        chk("held_wc_empty", 32'(o_empty), 32'd1);
        chk("held_wc_data", 32'(o_buffer2_data[31:8]), 32'(lit(8'd9)));

        // Simultaneous strobes while empty
        load(vd);
        i_save = 1'b1;
        i_write_complete = 1'b1;
        tick();
        i_save = 1'b0;
        i_write_complete = 1'b0;
        @(negedge clk);
        chk("simul_full", 32'(o_full), 32'd1);
        chk("simul_data", 32'(o_buffer2_data[31:8]), 32'(lit(8'd99)));

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 9; k++) s[k] = 8'($urandom_range(0, 255));
            i_save           = ($urandom_range(0, 7) == 0);
            i_write_complete = ($urandom_range(0, 2) == 0);
            n_rst            = ($urandom_range(0, 499) != 0);
            tick();
        end
        n_rst = 1'b1;
        i_save = 1'b0;
        i_write_complete = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
